// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl: instruction prefetch sequencer.
// Walks a word-aligned fetch PC through address translation (MMU) and an
// instruction-cache read, then writes each returned word into a fetch buffer.
// Only one icache request is ever outstanding. A new fetch starts only when
// the buffer still has room for the word it will return.
//
// Ports:
//   clk            system clock, rising-edge active
//   rst_n          asynchronous reset, asserted HIGH
//   clear_i        flush: restart fetching at start_pc_i
//   start_pc_i     redirect address, sampled with clear_i
//   buf_count_i    current fetch buffer occupancy
//   mmu_req_o      translation request (level, held until mmu_hit_i)
//   mmu_vaddr_o    virtual word address being fetched (the fetch PC)
//   mmu_hit_i      translation valid
//   mmu_paddr_i    translated physical address, valid with mmu_hit_i
//   icache_req_o   icache read request (level, held until icache_ack_i)
//   icache_addr_o  physical word address for the icache
//   icache_ack_i   icache response valid
//   icache_instr_i fetched word, valid with icache_ack_i
//   buf_wr_o       single-cycle fetch buffer write strobe
//   buf_wdata_o    word written with buf_wr_o
//   busy_o         controller is not idle
module prefetch_ctrl #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear_i,
   input  logic [31:0]            start_pc_i,
   input  logic [$clog2(DEPTH):0] buf_count_i,
   output logic                   mmu_req_o,
   output logic [31:0]            mmu_vaddr_o,
   input  logic                   mmu_hit_i,
   input  logic [31:0]            mmu_paddr_i,
   output logic                   icache_req_o,
   output logic [31:0]            icache_addr_o,
   input  logic                   icache_ack_i,
   input  logic [31:0]            icache_instr_i,
   output logic                   buf_wr_o,
   output logic [31:0]            buf_wdata_o,
   output logic                   busy_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   // One extra bit so that occupancy + 1 cannot wrap for any DEPTH.
   localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      XLATE,
      FETCH,
      DROP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] icache_addr_q, icache_addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        buf_wr_q, buf_wr_d;
   logic        mmu_req_q, icache_req_q, busy_q;

   logic [CW:0] count_x;
   logic [CW:0] count_inc;
   logic        room_now;
   logic        room_after;
   logic [31:0] start_al;
   logic        unused_low_bits;

   assign count_x    = {1'b0, buf_count_i};
   assign count_inc  = count_x + (CW + 1)'(1);
   assign room_now   = count_x < DEPTH_X;
   assign room_after = count_inc < DEPTH_X;
   assign start_al   = {start_pc_i[31:2], 2'b00};

   // Low address bits are always forced to zero, so they are never consumed.
   assign unused_low_bits = ^{start_pc_i[1:0], mmu_paddr_i[1:0]};

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      icache_addr_d = icache_addr_q;
      wdata_d       = wdata_q;
      buf_wr_d      = 1'b0;
      case (state_q)
         IDLE: begin
            // A word written last cycle is not yet visible in buf_count_i,
            // so wait one cycle after a write before judging free space.
            if (clear_i) begin
               fetch_pc_d = start_al;
            end else if (room_now && !buf_wr_q) begin
               state_d = XLATE;
            end
         end
         XLATE: begin
            if (clear_i) begin
               fetch_pc_d = start_al;
               state_d    = IDLE;
            end else if (mmu_hit_i) begin
               icache_addr_d = {mmu_paddr_i[31:2], 2'b00};
               state_d       = FETCH;
            end
         end
         FETCH: begin
            if (clear_i) begin
               // A request still in flight must be drained in DROP.
               fetch_pc_d = start_al;
               state_d    = icache_ack_i ? IDLE : DROP;
            end else if (icache_ack_i) begin
               buf_wr_d   = 1'b1;
               wdata_d    = icache_instr_i;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = room_after ? XLATE : IDLE;
            end
         end
         DROP: begin
            if (clear_i) begin
               fetch_pc_d = start_al;
            end
            if (icache_ack_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q       <= IDLE;
         fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
         icache_addr_q <= '0;
         wdata_q       <= '0;
         buf_wr_q      <= 1'b0;
         mmu_req_q     <= 1'b0;
         icache_req_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         icache_addr_q <= icache_addr_d;
         wdata_q       <= wdata_d;
         buf_wr_q      <= buf_wr_d;
         mmu_req_q     <= (state_d == XLATE);
         icache_req_q  <= (state_d == FETCH);
         busy_q        <= (state_d != IDLE);
      end
   end

   assign mmu_req_o     = mmu_req_q;
   assign mmu_vaddr_o   = fetch_pc_q;
   assign icache_req_o  = icache_req_q;
   assign icache_addr_o = icache_addr_q;
   assign buf_wr_o      = buf_wr_q;
   assign buf_wdata_o   = wdata_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_prefetch_ctrl.sv
// tb_prefetch_ctrl: self-checking bench for prefetch_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_prefetch_ctrl;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic                   clk;
   logic                   rst_n;
   logic                   clear;
   logic [31:0]            start_pc;
   logic [$clog2(DEPTH):0] buf_count;
   logic                   mmu_req_o;
   logic [31:0]            mmu_vaddr_o;
   logic                   hit;
   logic [31:0]            paddr;
   logic                   icache_req_o;
   logic [31:0]            icache_addr_o;
   logic                   ack;
   logic [31:0]            instr;
   logic                   buf_wr_o;
   logic [31:0]            buf_wdata_o;
   logic                   busy_o;

   int n_chk  = 0;
   int n_fail = 0;

   prefetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (clear),
      .start_pc_i    (start_pc),
      .buf_count_i   (buf_count),
      .mmu_req_o     (mmu_req_o),
      .mmu_vaddr_o   (mmu_vaddr_o),
      .mmu_hit_i     (hit),
      .mmu_paddr_i   (paddr),
      .icache_req_o  (icache_req_o),
      .icache_addr_o (icache_addr_o),
      .icache_ack_i  (ack),
      .icache_instr_i(instr),
      .buf_wr_o      (buf_wr_o),
      .buf_wdata_o   (buf_wdata_o),
      .busy_o        (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  cnt;
      logic        hit;
      logic [31:0] pa;
      logic        ack;
      logic [31:0] ins;
      logic        e_mreq;
      logic [31:0] e_va;
      logic        e_ireq;
      logic [31:0] e_ia;
      logic        e_wr;
      logic [31:0] e_wd;
      logic        e_busy;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] cnt, input logic h, input logic [31:0] pa,
                               input logic a, input logic [31:0] ins, input logic mr,
                               input logic [31:0] va, input logic ir, input logic [31:0] ia,
                               input logic wr, input logic [31:0] wd, input logic bz);
      vec_t v;
      v.cnt = cnt; v.hit = h; v.pa = pa; v.ack = a; v.ins = ins;
      v.e_mreq = mr; v.e_va = va; v.e_ireq = ir; v.e_ia = ia;
      v.e_wr = wr; v.e_wd = wd; v.e_busy = bz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] xlat(input logic [31:0] v);
      return v ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] hashf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   task automatic idle_inputs();
      clear = 1'b0; start_pc = '0; hit = 1'b0; paddr = '0; ack = 1'b0; instr = '0;
   endtask

   // Holds reset for two cycles, checks the reset image, releases on a falling edge.
   task automatic do_reset();
      rst_n = 1'b1;
      idle_inputs();
      buf_count = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mreq", mmu_req_o, 0);
      chk("rst_va", mmu_vaddr_o, RESET_PC);
      chk("rst_ireq", icache_req_o, 0);
      chk("rst_ia", icache_addr_o, 0);
      chk("rst_wr", buf_wr_o, 0);
      chk("rst_wd", buf_wdata_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_n = 1'b0;
   endtask

   // From any state heading to XLATE: wait (bounded) for the request, answer
   // with a hit, and return on the falling edge of the first FETCH cycle.
   task automatic go_fetch(input logic [31:0] pa);
      int unsigned k = 0;
      while (!mmu_req_o && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("gf_mreq", mmu_req_o, 1);
      hit = 1'b1; paddr = pa;
      @(negedge clk);
      hit = 1'b0;
      chk("gf_ireq", icache_req_o, 1);
   endtask

   vec_t vt[21];

   initial begin
      int unsigned pend;
      logic [31:0] pend_addr;
      logic [31:0] exp_pc;
      logic [31:0] r;
      int cnt;
      int cnt_now;
      int writes;

      // Buffer count as a real buffer would report it: a write becomes
      // visible the cycle after buf_wr_o.
      vt[0]  = mk(0, 0, 0,            1, 32'h5555_5555, 0, 32'h8000_0000, 0, 0,            0, 0,            0);
      vt[1]  = mk(0, 0, 0,            0, 0,             1, 32'h8000_0000, 0, 0,            0, 0,            1);
      vt[2]  = mk(0, 1, 32'h1234_5677, 0, 0,            1, 32'h8000_0000, 0, 0,            0, 0,            1);
      vt[3]  = mk(0, 1, 32'hFFFF_FFFF, 0, 0,            0, 32'h8000_0000, 1, 32'h1234_5674, 0, 0,          1);
      vt[4]  = mk(0, 0, 0,            0, 0,             0, 32'h8000_0000, 1, 32'h1234_5674, 0, 0,          1);
      vt[5]  = mk(0, 0, 0,            1, 32'hDEAD_BEEF, 0, 32'h8000_0000, 1, 32'h1234_5674, 0, 0,          1);
      vt[6]  = mk(0, 0, 0,            0, 0,             1, 32'h8000_0004, 0, 0,            1, 32'hDEAD_BEEF, 1);
      vt[7]  = mk(1, 1, 32'h2000_0001, 0, 0,            1, 32'h8000_0004, 0, 0,            0, 0,            1);
      vt[8]  = mk(1, 0, 0,            0, 0,             0, 32'h8000_0004, 1, 32'h2000_0000, 0, 0,          1);
      vt[9]  = mk(1, 0, 0,            0, 0,             0, 32'h8000_0004, 1, 32'h2000_0000, 0, 0,          1);
      vt[10] = mk(1, 0, 0,            1, 32'h0BAD_F00D, 0, 32'h8000_0004, 1, 32'h2000_0000, 0, 0,          1);
      vt[11] = mk(1, 0, 0,            0, 0,             0, 32'h8000_0008, 0, 0,            1, 32'h0BAD_F00D, 0);
      vt[12] = mk(2, 0, 0,            0, 0,             0, 32'h8000_0008, 0, 0,            0, 0,            0);
      vt[13] = mk(2, 0, 0,            0, 0,             0, 32'h8000_0008, 0, 0,            0, 0,            0);
      vt[14] = mk(2, 0, 0,            0, 0,             0, 32'h8000_0008, 0, 0,            0, 0,            0);
      vt[15] = mk(1, 0, 0,            0, 0,             0, 32'h8000_0008, 0, 0,            0, 0,            0);
      vt[16] = mk(1, 1, 32'h3000_0008, 0, 0,            1, 32'h8000_0008, 0, 0,            0, 0,            1);
      vt[17] = mk(1, 0, 0,            1, 32'h1111_2222, 0, 32'h8000_0008, 1, 32'h3000_0008, 0, 0,          1);
      vt[18] = mk(1, 0, 0,            0, 0,             0, 32'h8000_000C, 0, 0,            1, 32'h1111_2222, 0);
      vt[19] = mk(2, 0, 0,            0, 0,             0, 32'h8000_000C, 0, 0,            0, 0,            0);
      vt[20] = mk(2, 0, 0,            0, 0,             0, 32'h8000_000C, 0, 0,            0, 0,            0);

      do_reset();
      for (int i = 0; i < 21; i++) begin
         chk($sformatf("vec%0d_mreq", i), mmu_req_o, vt[i].e_mreq);
         chk($sformatf("vec%0d_va", i), mmu_vaddr_o, vt[i].e_va);
         chk($sformatf("vec%0d_ireq", i), icache_req_o, vt[i].e_ireq);
         chk($sformatf("vec%0d_wr", i), buf_wr_o, vt[i].e_wr);
         chk($sformatf("vec%0d_busy", i), busy_o, vt[i].e_busy);
         if (vt[i].e_ireq) chk($sformatf("vec%0d_ia", i), icache_addr_o, vt[i].e_ia);
         if (vt[i].e_wr) chk($sformatf("vec%0d_wd", i), buf_wdata_o, vt[i].e_wd);
         buf_count = vt[i].cnt;
         hit = vt[i].hit; paddr = vt[i].pa;
         ack = vt[i].ack; instr = vt[i].ins;
         @(negedge clk);
      end
      idle_inputs();

      // Redirect while FETCH is waiting; the ack arrives three cycles later.
      buf_count = '0;
      go_fetch(32'h0000_4000);
      clear = 1'b1; start_pc = 32'h0000_1002;
      @(negedge clk);
      clear = 1'b0;
      chk("drop_ireq", icache_req_o, 0);
      chk("drop_va", mmu_vaddr_o, 32'h0000_1000);
      for (int k = 0; k < 3; k++) begin
         chk("drop_busy", busy_o, 1);
         chk("drop_wr", buf_wr_o, 0);
         chk("drop_mreq", mmu_req_o, 0);
         if (k == 2) ack = 1'b1;
         @(negedge clk);
      end
      ack = 1'b0;
      chk("drop_done_busy", busy_o, 0);
      chk("drop_done_wr", buf_wr_o, 0);
      @(negedge clk);
      chk("drop_next_mreq", mmu_req_o, 1);
      chk("drop_next_va", mmu_vaddr_o, 32'h0000_1000);
      chk("drop_next_wr", buf_wr_o, 0);

      // Clear and ack in the same FETCH cycle: data discarded.
      go_fetch(32'h0000_5000);
      clear = 1'b1; start_pc = 32'h0000_2007; ack = 1'b1; instr = 32'hCAFE_F00D;
      @(negedge clk);
      clear = 1'b0; ack = 1'b0; buf_count = 2'd2;
      chk("clrack_wr", buf_wr_o, 0);
      chk("clrack_busy", busy_o, 0);
      chk("clrack_ireq", icache_req_o, 0);
      chk("clrack_va", mmu_vaddr_o, 32'h0000_2004);
      ack = 1'b1; instr = 32'h7777_7777;
      @(negedge clk);
      ack = 1'b0;
      chk("stray_ack_wr", buf_wr_o, 0);
      chk("stray_ack_busy", busy_o, 0);

      // fetch_pc wraps past the top of the address space.
      buf_count = '0; clear = 1'b1; start_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      clear = 1'b0;
      chk("wrap_va0", mmu_vaddr_o, 32'hFFFF_FFFC);
      chk("wrap_busy0", busy_o, 0);
      go_fetch(32'h0000_6000);
      ack = 1'b1; instr = 32'h1234_5678;
      @(negedge clk);
      ack = 1'b0;
      chk("wrap_wr", buf_wr_o, 1);
      chk("wrap_wd", buf_wdata_o, 32'h1234_5678);
      chk("wrap_va1", mmu_vaddr_o, 32'h0000_0000);
      chk("wrap_mreq", mmu_req_o, 1);
      clear = 1'b1; start_pc = 32'h0000_3001; buf_count = 2'd2;
      @(negedge clk);
      clear = 1'b0;
      chk("xclr_mreq", mmu_req_o, 0);
      chk("xclr_busy", busy_o, 0);
      chk("xclr_va", mmu_vaddr_o, 32'h0000_3000);

      // Reset in FETCH, response arrives after release.
      buf_count = '0;
      go_fetch(32'h0000_7000);
      rst_n = 1'b1;
      #1;
      chk("rfetch_busy", busy_o, 0);
      chk("rfetch_ireq", icache_req_o, 0);
      chk("rfetch_va", mmu_vaddr_o, RESET_PC);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      ack = 1'b1; instr = 32'h0000_0BAD;
      @(negedge clk);
      ack = 1'b0;
      chk("rlate_wr", buf_wr_o, 0);
      chk("rlate_mreq", mmu_req_o, 1);
      chk("rlate_va", mmu_vaddr_o, RESET_PC);
      chk("rlate_ireq", icache_req_o, 0);

      // Randomised run against a word-stream model: every buffered word must
      // be the icache contents of the translation of the next expected PC.
      do_reset();
      pend = 0; pend_addr = '0; exp_pc = RESET_PC; cnt = 0; writes = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         cnt_now = cnt;
         if (buf_wr_o) begin
            chk("rnd_wdata", buf_wdata_o, hashf(xlat(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            cnt++;
            writes++;
            chk("rnd_no_overflow", (cnt <= int'(DEPTH)) ? 32'd1 : 32'd0, 1);
         end
         if (mmu_req_o) chk("rnd_vaddr", mmu_vaddr_o, exp_pc);
         if (pend != 0) chk("rnd_one_outstanding", mmu_req_o, 0);
         if (icache_req_o) begin
            if (pend != 0) begin
               chk("rnd_ia_stable", icache_addr_o, pend_addr);
            end else begin
               pend = 1;
               pend_addr = icache_addr_o;
               chk("rnd_ia_align", {30'd0, icache_addr_o[1:0]}, 0);
            end
         end
         if (mmu_req_o) begin
            hit = ($urandom % 2) == 0;
            paddr = xlat(mmu_vaddr_o) | ($urandom % 4);
         end else begin
            hit = ($urandom % 4) == 0;
            paddr = $urandom;
         end
         if (pend != 0 && ($urandom % 3) == 0) begin
            ack = 1'b1; instr = hashf(pend_addr); pend = 0;
         end else if (pend == 0 && ($urandom % 4) == 0) begin
            ack = 1'b1; instr = $urandom;
         end else begin
            ack = 1'b0; instr = $urandom;
         end
         if (cnt_now > 0 && ($urandom % 3) == 0) cnt--;
         clear = ($urandom % 20) == 0;
         r = $urandom;
         if (($urandom % 4) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
         start_pc = r;
         if (clear) begin
            exp_pc = {r[31:2], 2'b00};
            cnt = 0;
         end
         buf_count = cnt_now[$clog2(DEPTH):0];
      end
      idle_inputs();
      chk("rnd_progress", (writes >= 100) ? 32'd1 : 32'd0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prefetch_ctrl.md
PREFETCH_CTRL -- requirements
Module: prefetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the fetch buffer capacity in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous reset, asserted high.
REQ-006 clear_i  in  1  flush request; restart fetch at start_pc_i.
REQ-007 start_pc_i  in  32  redirect address, sampled when clear_i=1.
REQ-008 buf_count_i  in  $clog2(DEPTH)+1  current fetch buffer occupancy.
REQ-009 mmu_req_o  out  1  translation request.
REQ-010 mmu_vaddr_o  out  32  virtual word address to translate.
REQ-011 mmu_hit_i  in  1  translation valid this cycle.
REQ-012 mmu_paddr_i  in  32  translated physical address, valid with mmu_hit_i.
REQ-013 icache_req_o  out  1  instruction cache read request.
REQ-014 icache_addr_o  out  32  physical word address for the icache.
REQ-015 icache_ack_i  in  1  icache response valid.
REQ-016 icache_instr_i  in  32  fetched word, valid with icache_ack_i.
REQ-017 buf_wr_o  out  1  single-cycle write strobe into the fetch buffer.
REQ-018 buf_wdata_o  out  32  word written with buf_wr_o.
REQ-019 busy_o  out  1  state is not IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, XLATE, FETCH and DROP.
REQ-021 SHALL hold a fetch_pc register with fetch_pc[1:0] always 0; mmu_vaddr_o SHALL equal fetch_pc.
REQ-022 IDLE -> XLATE when clear_i=0 and buf_count_i < DEPTH; otherwise remain in IDLE.
REQ-023 XLATE: mmu_req_o=1 and held; on mmu_hit_i, register {mmu_paddr_i[31:2],2'b00} into icache_addr_o and go to FETCH next cycle.
REQ-024 FETCH: icache_req_o=1, held level until icache_ack_i; icache_addr_o SHALL be stable throughout.
REQ-025 FETCH with icache_ack_i and clear_i=0: assert buf_wr_o=1 with buf_wdata_o=icache_instr_i on the following cycle, and increment fetch_pc by 4.
REQ-026 After the REQ-025 write, SHALL go to XLATE if buf_count_i+1 < DEPTH, else to IDLE.
REQ-027 Latency SHALL be: translation hit at cycle N, icache request from N+1, ack at cycle M, buf_wr_o at M+1.
REQ-028 SHALL never have more than one outstanding icache request, and SHALL never issue a fetch that would overflow the buffer.
REQ-029 clear_i in IDLE or XLATE: fetch_pc <= {start_pc_i[31:2],2'b00}, drop mmu_req_o, go to IDLE; no buffer write.
REQ-030 clear_i in FETCH without icache_ack_i: load fetch_pc as in REQ-029, drop icache_req_o, go to DROP.
REQ-031 clear_i in FETCH with icache_ack_i in the same cycle: discard the data (no buf_wr_o), load fetch_pc, go to IDLE.
REQ-032 DROP: icache_req_o=0; on icache_ack_i discard the data and go to IDLE.
REQ-033 clear_i in DROP: reload fetch_pc and stay in DROP until the ack arrives.
REQ-034 fetch_pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-035 mmu_hit_i outside XLATE and icache_ack_i outside FETCH/DROP SHALL be ignored.
REQ-036 clear_i SHALL take priority over all other same-cycle events.

Reset
REQ-037 While rst_n=1, the FSM SHALL be IDLE, fetch_pc=RESET_PC with bits [1:0] forced 0, and all outputs 0 except mmu_vaddr_o=RESET_PC.
REQ-038 Reset asserted mid-transaction SHALL abandon any pending response; an icache_ack_i arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-039 Reset release, buf_count_i=0, mmu_hit_i one cycle after request, ack two cycles after request -> mmu_vaddr_o=8000_0000, then 8000_0004, with buf_wr_o pulsed twice, then IDLE (count=2).
REQ-040 buf_count_i=2 held -> busy_o=0, no mmu_req_o; drop to 1 -> exactly one fetch issued.
REQ-041 clear_i with start_pc_i=0000_1002 while in FETCH, ack 3 cycles later -> DROP, no buf_wr_o, next mmu_vaddr_o=0000_1000.
REQ-042 clear_i and icache_ack_i in the same FETCH cycle -> no buf_wr_o, IDLE, fetch_pc=start_pc aligned.
REQ-043 fetch_pc=FFFF_FFFC, successful fetch -> next mmu_vaddr_o=0000_0000.
REQ-044 rst_n asserted in FETCH, late icache_ack_i after release -> no buf_wr_o, fetch restarts at RESET_PC.
